// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared constants, FSM state type and activation function for act_share_sched
package act_pkg;

    localparam int          FP_SIGN_BIT = 31;
    localparam int          FP_EXP_MSB  = 30;
    localparam int          FP_EXP_LSB  = 23;
    localparam logic [7:0]  FP_EXP_INF  = 8'hFF;
    localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } sched_state_t;

    // ReLU / LeakyReLU on fp32; the leaky slope is a power of two, so it is an exponent subtract
    function automatic logic [31:0] act_apply(input logic [31:0] x, input logic leaky,
                                              input logic [4:0] shift);
        logic [7:0] e;
        e = x[FP_EXP_MSB:FP_EXP_LSB];
        act_apply = x;
        if (x[FP_SIGN_BIT] && (e != FP_EXP_INF)) begin
            if (!leaky) begin
                act_apply = 32'h0000_0000;
            end else if (e > {3'b000, shift}) begin
                act_apply = {1'b1, e - {3'b000, shift}, x[22:0]};
            end else begin
                act_apply = FP_NEG_ZERO;
            end
        end
    endfunction

endpackage

// File: rtl/act_rr_arbiter.sv
// rtl/act_rr_arbiter.sv - combinational round-robin arbiter, searches upward from ptr with wrap
module act_rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic         w_found;
    int           w_sum;
    logic [W-1:0] w_idx;

    // first requester at or above ptr wins; one-hot grant plus its index
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = int'(ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = W'(w_sum);
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/act_share_sched.sv
// rtl/act_share_sched.sv - shared fp32 ReLU/LeakyReLU scheduler; optional counters under ACT_PERF_CNT_EN
module act_share_sched
    import act_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int PIPE_STAGES = 2,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    input  logic                  resp_ready,
    input  logic                  cfg_wr,
    input  logic                  cfg_leaky,
    input  logic [4:0]            cfg_shift,
    output logic                  cfg_ack,
    output logic                  busy
`ifdef ACT_PERF_CNT_EN
    ,
    input  logic                  perf_clr,
    output logic [NUM_REQ*16-1:0] perf_grant_cnt,
    output logic [15:0]           perf_stall_cnt
`endif
);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [ID_W-1:0]      r_ptr;
    logic                 r_leaky;
    logic [4:0]           r_shift;
    logic [PIPE_STAGES-1:0] r_vld;
    logic [31:0]          r_data [PIPE_STAGES];
    logic [ID_W-1:0]      r_id   [PIPE_STAGES];

    logic                 w_stall;
    logic                 w_grant_en;
    logic [NUM_REQ-1:0]   w_req_masked;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]      w_gnt_idx;
    logic                 w_accept;
    logic [31:0]          w_operand;
    logic [31:0]          w_result;

    assign w_stall      = r_vld[PIPE_STAGES-1] & ~resp_ready;
    assign w_grant_en   = (r_state == RUN) & ~cfg_wr & ~w_stall;
    assign w_req_masked = req_valid & {NUM_REQ{w_grant_en}};

    act_rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_arb (
        .req     (w_req_masked),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;

    // operand mux driven by the one-hot grant
    always_comb begin
        w_operand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_operand = req_data[32*i +: 32];
            end
        end
    end

    // the result is computed at accept so it carries the config active at that moment
    assign w_result = act_apply(w_operand, r_leaky, r_shift);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: stop granting, wait for the pipe to empty, then swap config
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (cfg_wr) w_state_nxt = DRAIN;
            DRAIN:   if (!busy)  w_state_nxt = APPLY;
            APPLY:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    assign cfg_ack = (r_state == APPLY);

    // config latch, loaded only in APPLY when nothing is in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_leaky <= 1'b0;
            r_shift <= '0;
        end else if (r_state == APPLY) begin
            r_leaky <= cfg_leaky;
            r_shift <= cfg_shift;
        end
    end

    // round-robin pointer moves past the winner on every accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        end
    end

    // tagged pipeline; every stage freezes while the output is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_data[s] <= '0;
                r_id[s]   <= '0;
            end
        end else if (!w_stall) begin
            r_vld[0]  <= w_accept;
            r_data[0] <= w_result;
            r_id[0]   <= w_gnt_idx;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_data[s] <= r_data[s-1];
                r_id[s]   <= r_id[s-1];
            end
        end
    end

    assign resp_valid = r_vld[PIPE_STAGES-1];
    assign resp_data  = r_data[PIPE_STAGES-1];
    assign resp_id    = r_id[PIPE_STAGES-1];
    assign busy       = |r_vld;

`ifdef ACT_PERF_CNT_EN
    logic [15:0] r_grant_cnt [NUM_REQ];
    logic [15:0] r_stall_cnt;

    // saturating per-requester accept counters and stall-cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n || perf_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_gnt[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // flatten counters onto the output bus
    always_comb begin
        perf_grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_grant_cnt[16*i +: 16] = r_grant_cnt[i];
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`else
    // counters not built
`endif

endmodule

// File: tb/tb_act_share_sched.sv
// tb/tb_act_share_sched.sv - randomized and directed bench for act_share_sched against a queue model
module tb_act_share_sched;

    localparam int N    = 4;
    localparam int PIPE = 2;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic [31:0]     resp_data;
    logic [IDW-1:0]  resp_id;
    logic            resp_ready;
    logic            cfg_wr;
    logic            cfg_leaky;
    logic [4:0]      cfg_shift;
    logic            cfg_ack;
    logic            busy;
`ifdef ACT_PERF_CNT_EN
    logic            perf_clr;
    logic [N*16-1:0] perf_grant_cnt;
    logic [15:0]     perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    act_share_sched #(.NUM_REQ(N), .PIPE_STAGES(PIPE), .ID_W(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .cfg_wr     (cfg_wr),
        .cfg_leaky  (cfg_leaky),
        .cfg_shift  (cfg_shift),
        .cfg_ack    (cfg_ack),
        .busy       (busy)
`ifdef ACT_PERF_CNT_EN
        ,
        .perf_clr       (perf_clr),
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] d;
        int          id;
        int          rem;
    } item_t;

    item_t       q[$];
    int          m_ptr, m_state, m_shift;
    bit          m_leaky;
    int          n_vec, n_err, cyc, n_acc, n_resp, last_acc_cyc, last_resp_cyc;
    logic [31:0] obs_data[$];
    int          obs_id[$];
    logic [N-1:0] s_rdy;
    logic [31:0] s_data;
    bit          s_busy, s_ack, s_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] act_ref(input logic [31:0] x, input bit lk, input int sh);
        int e;
        e = int'(x[30:23]);
        if (!x[31] || e == 255) return x;
        if (!lk) return 32'h0;
        if (e > sh) return {1'b1, 8'(e - sh), x[22:0]};
        return 32'h8000_0000;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        case ($urandom_range(0, 3))
            0:       e = 8'hFF;
            1:       e = 8'($urandom_range(0, 255));
            default: e = 8'($urandom_range(0, 12));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // one clock: compare DUT against the model, then advance the model across the edge
    task automatic tick();
        int gi;
        bit ev, st, bsy;
        logic [N-1:0] er;
        #2;
        s_rdy  = req_ready;
        s_data = resp_data;
        s_busy = busy;
        s_ack  = cfg_ack;
        s_acc  = |(req_ready & req_valid);
        if (rst_n) begin
            ev = (q.size() > 0) && (q[0].rem == 0);
            st = ev && !resp_ready;
            bsy = q.size() > 0;
            gi = -1;
            er = '0;
            if (m_state == 0 && !cfg_wr && !st) begin
                for (int k = 0; k < N; k++) begin
                    if (gi < 0 && req_valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
                end
            end
            if (gi >= 0) er[gi] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("resp_valid", resp_valid, ev);
            if (ev) begin
                chk("resp_data", resp_data, q[0].d);
                chk("resp_id", resp_id, q[0].id);
            end
            chk("busy", busy, bsy);
            chk("cfg_ack", cfg_ack, m_state == 2);
            if (s_acc) begin
                n_acc++;
                last_acc_cyc = cyc;
            end
            if (resp_valid && resp_ready) begin
                n_resp++;
                last_resp_cyc = cyc;
                obs_data.push_back(resp_data);
                obs_id.push_back(int'(resp_id));
            end
            if (ev && resp_ready) void'(q.pop_front());
            if (!st) foreach (q[i]) q[i].rem--;
            if (gi >= 0) begin
                q.push_back('{act_ref(req_data[32*gi +: 32], m_leaky, m_shift), gi, PIPE - 1});
                m_ptr = (gi + 1) % N;
            end
            case (m_state)
                0: if (cfg_wr) m_state = 1;
                1: if (!bsy) m_state = 2;
                default: begin
                    m_leaky = cfg_leaky;
                    m_shift = int'(cfg_shift);
                    m_state = 0;
                end
            endcase
        end else begin
            q.delete();
            m_ptr = 0; m_state = 0; m_leaky = 0; m_shift = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_cfg(input bit lk, input int sh);
        bit got;
        got = 0;
        resp_ready = 1'b1;
        cfg_leaky = lk;
        cfg_shift = 5'(sh);
        cfg_wr = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (s_ack) begin
                got = 1;
                break;
            end
        end
        cfg_wr = 1'b0;
        chk("cfg_ack_seen", got, 1'b1);
    endtask

    task automatic send(input int idx, input logic [31:0] d);
        bit got;
        got = 0;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_data[32*idx +: 32] = d;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (s_acc) begin
                got = 1;
                break;
            end
        end
        req_valid = '0;
        chk("send_accept", got, 1'b1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        req_valid = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!s_busy) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        int n_before;
        rst_n = 0; req_valid = '0; req_data = '0; resp_ready = 1'b1;
        cfg_wr = 0; cfg_leaky = 0; cfg_shift = '0;
`ifdef ACT_PERF_CNT_EN
        perf_clr = 0;
`endif
        @(negedge clk);
        tick();
        tick();
        rst_n = 1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_cfg_ack", cfg_ack, 0);
        chk("rst_busy", busy, 0);
        tick();

        // all requesters streaming: grants rotate 0,1,2,3 at one per cycle
        obs_id.delete();
        n_before = n_acc;
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = rand_fp();
        req_valid = '1;
        for (int i = 0; i < 8; i++) tick();
        chk("rr_accepts", n_acc - n_before, 8);
        drain();
        for (int i = 0; i < 8; i++) chk("rr_order", obs_id[i], i % N);

        // single operand, leaky shift 2, latency check
        do_cfg(1, 2);
        obs_data.delete(); obs_id.delete();
        send(0, 32'hC080_0000);
        drain();
        chk("t1_data", obs_data[0], 32'hBF80_0000);
        chk("t1_id", obs_id[0], 0);
        chk("t1_latency", last_resp_cyc - last_acc_cyc, PIPE);

        // backpressure with a full pipe
        req_valid = '1;
        for (int i = 0; i < 3; i++) tick();
        resp_ready = 1'b0;
        tick();
        held = s_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", s_data, held);
            chk("stall_no_grant", s_rdy, 0);
        end
        drain();
        chk("stall_no_loss", n_resp, n_acc);

        // config change with two results in flight
        do_cfg(0, 0);
        obs_data.delete();
        req_valid = 4'b0001;
        req_data[31:0] = 32'hC000_0000;
        tick();
        tick();
        req_valid = '0;
        do_cfg(1, 1);
        chk("t4_drained", obs_data.size(), 2);
        chk("t4_relu0", obs_data[0], 32'h0);
        chk("t4_relu1", obs_data[1], 32'h0);
        send(1, 32'hC000_0000);
        drain();
        chk("t4_leaky", obs_data[2], 32'hBF80_0000);

        // boundary values
        do_cfg(1, 3);
        obs_data.delete();
        send(2, 32'h8080_0000);
        send(2, 32'hFF80_0000);
        send(2, 32'h7FC0_0000);
        drain();
        do_cfg(0, 0);
        send(3, 32'hBF80_0000);
        drain();
        chk("t5_flush", obs_data[0], 32'h8000_0000);
        chk("t5_neginf", obs_data[1], 32'hFF80_0000);
        chk("t5_nan", obs_data[2], 32'h7FC0_0000);
        chk("t5_relu", obs_data[3], 32'h0);

        // reset with results in flight
        do_cfg(1, 4);
        req_valid = 4'b0001;
        req_data[31:0] = 32'hC100_0000;
        tick();
        tick();
        req_valid = '0;
        rst_n = 0;
        tick();
        rst_n = 1;
        n_before = n_resp;
`ifdef ACT_PERF_CNT_EN
        #1;
        chk("perf_grant_rst", perf_grant_cnt, 0);
        chk("perf_stall_rst", perf_stall_cnt, 0);
`endif
        for (int i = 0; i < 4; i++) tick();
        chk("t6_no_resp", n_resp, n_before);
        n_acc = n_resp;
        req_valid = '1;
        tick();
        chk("t6_ptr0", s_rdy, 4'b0001);
        drain();
        obs_data.delete();
        send(3, 32'hBF80_0000);
        drain();
        chk("t6_relu", obs_data[0], 32'h0);

        // randomized traffic with occasional config updates
        for (int c = 0; c < 600; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) req_data[32*i +: 32] = rand_fp();
            resp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) do_cfg($urandom_range(0, 1) == 1, int'($urandom_range(0, 9)));
            tick();
        end
        drain();
        chk("final_no_loss", n_resp, n_acc);
        chk("final_model_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
